i2s_receiver: RTL and testbench

- I2S capture path: deserialises the codec ADC serial stream (ADAU record path) into parallel left/right sample pairs in the clk domain.
- Pairs with the transmit-side i2s_master. The FPGA drives bclk/lrclk, and this block only observes them.
- Output is a valid/ready frame interface feeding an audio processing block or a loopback into the transmit path.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_rx_sync.sv | 42 ++++
 rtl/i2s_receiver.sv | 175 +++++++++++++++++
 tb/tb_i2s_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM state encoding, channel codes and default geometry.
// Used by both the receive path (i2s_receiver) and the transmit side (i2s_master).
`timescale 1ns/1ps
package i2s_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  localparam int unsigned DEFAULT_WIDTH       = 24;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for bclk/lrclk/sdata into the clk domain, plus bclk rise pulse.
// All three inputs share the same depth so data and word select stay aligned to the rise.
`timescale 1ns/1ps
module i2s_rx_sync
  import i2s_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bclk_i,
  input  logic lrclk_i,
  input  logic sdata_i,
  output logic sdata_o,
  output logic lrclk_o,
  output logic bclk_rise_o
);

  logic [SYNC_STAGES-1:0] bclk_q;
  logic [SYNC_STAGES-1:0] lrclk_q;
  logic [SYNC_STAGES-1:0] sdata_q;
  logic                   bclk_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_q      <= '0;
      lrclk_q     <= '0;
      sdata_q     <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_q      <= {bclk_q[SYNC_STAGES-2:0], bclk_i};
      lrclk_q     <= {lrclk_q[SYNC_STAGES-2:0], lrclk_i};
      sdata_q     <= {sdata_q[SYNC_STAGES-2:0], sdata_i};
      bclk_prev_q <= bclk_q[SYNC_STAGES-1];
    end
  end

  assign sdata_o     = sdata_q[SYNC_STAGES-1];
  assign lrclk_o     = lrclk_q[SYNC_STAGES-1];
  assign bclk_rise_o = bclk_q[SYNC_STAGES-1] & ~bclk_prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S capture path: deserialises L/R words into a valid/ready pair with a sticky overrun flag.
// Optional I2S_RX_OVERRUN_CNT_EN adds a saturating 16-bit dropped-pair counter port.
`timescale 1ns/1ps
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk,
  input  logic             lrclk,
  input  logic             sdata_in,
  output logic [WIDTH-1:0] frame_out_l,
  output logic [WIDTH-1:0] frame_out_r,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  output logic [15:0]      overrun_count
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic sdata_s, lrclk_s, rise;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk),
    .rst_i      (reset),
    .bclk_i     (bclk),
    .lrclk_i    (lrclk),
    .sdata_i    (sdata_in),
    .sdata_o    (sdata_s),
    .lrclk_o    (lrclk_s),
    .bclk_rise_o(rise)
  );

  logic [1:0]       state_q, state_d;
  logic             ch_q, ch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] l_hold_q, l_hold_d;
  logic             lr_prev_q, lr_prev_d;
  logic [WIDTH-1:0] frame_l_q, frame_l_d;
  logic [WIDTH-1:0] frame_r_q, frame_r_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             lr_edge;
  logic             pair_done;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    l_hold_d  = l_hold_q;
    lr_prev_d = lr_prev_q;
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    pair_done = 1'b0;
`ifdef I2S_RX_OVERRUN_CNT_EN
    ovf_cnt_d = ovf_cnt_q;
`endif
    lr_edge = rise && (lrclk_s != lr_prev_q);

    if (rise) begin
      lr_prev_d = lrclk_s;
      case (state_q)
        ST_IDLE: begin
          if (lr_edge && (lrclk_s == CH_L)) begin
            state_d = ST_SHIFT;
            ch_d    = CH_L;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          // A word-select change before the word is full means a short slot.
          if (lr_edge) begin
            state_d = ST_IDLE;
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], sdata_s};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              state_d = ST_WAIT;
              if (ch_q == CH_L) begin
                l_hold_d = shreg_d;
              end else begin
                pair_done = 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          if (lr_edge) begin
            if (lrclk_s != ch_q) begin
              state_d = ST_SHIFT;
              ch_d    = lrclk_s;
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (pair_done) begin
      if (!valid_q || ready) begin
        frame_l_d = l_hold_q;
        frame_r_d = shreg_d;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
`ifdef I2S_RX_OVERRUN_CNT_EN
        if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
`endif
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= CH_L;
      cnt_q     <= '0;
      shreg_q   <= '0;
      l_hold_q  <= '0;
      lr_prev_q <= 1'b0;
      frame_l_q <= '0;
      frame_r_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef I2S_RX_OVERRUN_CNT_EN
      ovf_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      l_hold_q  <= l_hold_d;
      lr_prev_q <= lr_prev_d;
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef I2S_RX_OVERRUN_CNT_EN
      ovf_cnt_q <= ovf_cnt_d;
`endif
    end
  end

  assign frame_out_l = frame_l_q;
  assign frame_out_r = frame_r_q;
  assign valid       = valid_q;
  assign overrun     = overrun_q;
`ifdef I2S_RX_OVERRUN_CNT_EN
  assign overrun_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: I2S source model, scoreboard queue and handshake monitor.
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         bclk, lrclk, sdata_in, ready;
  logic [W-1:0] frame_out_l, frame_out_r;
  logic         valid, overrun;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0]  overrun_count;
`endif

  i2s_receiver #(
    .WIDTH      (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata_in   (sdata_in),
    .frame_out_l(frame_out_l),
    .frame_out_r(frame_out_r),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun)
`ifdef I2S_RX_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_count = 0;
  logic [2*W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bclk period: falling edge drives lrclk/data, rising edge 160 ns later.
  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0;
    lrclk = lr;
    sdata_in = d;
    repeat (16) @(negedge clk);
    bclk = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Rise k=0 of a slot carries the previous slot's LSB; MSB follows on k=1.
  task automatic send_slot(input logic lr, input logic [W-1:0] w, input int n);
    logic d;
    for (int k = 0; k < n; k++) begin
      if (k >= 1 && k <= W) d = w[W-k];
      else d = 1'($urandom_range(0, 1));
      send_bit(lr, d);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit push);
    if (push) sb_q.push_back({l, r});
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(sb_q.size()), 64'd0);
  endtask

  // Handshake monitor: pops the scoreboard on every accepted pair, checks hold stability.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_l, prev_r;
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_l", 64'(frame_out_l), 64'(prev_l));
        chk("hold_r", 64'(frame_out_r), 64'(prev_r));
      end
      if (valid && ready) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_pair", 64'(valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("pair_l", 64'(frame_out_l), 64'(e[2*W-1:W]));
          chk("pair_r", 64'(frame_out_r), 64'(e[W-1:0]));
        end
      end
      prev_hold = valid && !ready;
      prev_l = frame_out_l;
      prev_r = frame_out_r;
    end
  end

  initial begin
    int hs0;
    logic [W-1:0] al, ar, bl, br;
    reset = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b1;
    sdata_in = 1'b0;
    ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_l", 64'(frame_out_l), 64'd0);
    chk("rst_r", 64'(frame_out_r), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    chk("rst_ovf_cnt", 64'(overrun_count), 64'd0);
`endif
    reset = 1'b0;

    // Start mid-right slot, then clean stream.
    send_slot(1'b1, 24'hFFFFFF, 10);
    hs0 = hs_count;
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
    wait_empty("clean_drain");
    chk("clean_hs", 64'(hs_count - hs0), 64'd2);
    chk("clean_overrun", 64'(overrun), 64'd0);

    // Short left slot (10 bits) is discarded.
    hs0 = hs_count;
    send_slot(1'b0, 24'h123456, 11);
    send_slot(1'b1, 24'h654321, 32);
    send_frame(24'h0F1E2D, 24'hC3B4A5, 1'b1);
    wait_empty("short_drain");
    chk("short_hs", 64'(hs_count - hs0), 64'd1);

    // Accept the held pair in the very cycle the next right word completes.
    al = 24'h111111; ar = 24'h222222; bl = 24'h333333; br = 24'h444444;
    set_ready(1'b0);
    send_frame(al, ar, 1'b1);
    @(negedge clk);
    fork
      send_frame(bl, br, 1'b1);
      begin
        #(56 * 320 + 160 + 16);
        chk("simul_pre_valid", 64'(valid), 64'd1);
        chk("simul_pre_l", 64'(frame_out_l), 64'(al));
        ready = 1'b1;
        #10 ready = 1'b0;
        chk("simul_valid", 64'(valid), 64'd1);
        chk("simul_l", 64'(frame_out_l), 64'(bl));
        chk("simul_r", 64'(frame_out_r), 64'(br));
        chk("simul_overrun", 64'(overrun), 64'd0);
      end
    join
    set_ready(1'b1);
    wait_empty("simul_drain");

    // Backpressure for three frames: first pair held, two dropped.
    set_ready(1'b0);
    send_frame(24'hABCDEF, 24'h012345, 1'b1);
    send_frame(24'h777777, 24'h888888, 1'b0);
    send_frame(24'h999999, 24'hAAAAAA, 1'b0);
    chk("bp_valid", 64'(valid), 64'd1);
    chk("bp_l", 64'(frame_out_l), 64'h00ABCDEF);
    chk("bp_r", 64'(frame_out_r), 64'h00012345);
    chk("bp_overrun", 64'(overrun), 64'd1);
`ifdef I2S_RX_OVERRUN_CNT_EN
    chk("bp_ovf_cnt", 64'(overrun_count), 64'd2);
`endif
    set_ready(1'b1);
    wait_empty("bp_drain");
    send_frame(24'hFEDCBA, 24'h0A0B0C, 1'b1);
    wait_empty("bp_after_drain");
    chk("bp_sticky", 64'(overrun), 64'd1);

    // Reset at bit 12 of the right word.
    send_slot(1'b0, 24'h5555AA, 32);
    send_slot(1'b1, 24'hAA5555, 13);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_l", 64'(frame_out_l), 64'd0);
    chk("mid_rst_r", 64'(frame_out_r), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    chk("mid_rst_ovf_cnt", 64'(overrun_count), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hs0 = hs_count;
    send_slot(1'b1, 24'h000000, 19);
    send_frame(24'hC0FFEE, 24'hBEEF01, 1'b1);
    wait_empty("mid_rst_drain");
    chk("mid_rst_hs", 64'(hs_count - hs0), 64'd1);
    chk("final_overrun", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
